// File: rtl/eth_tx_fbuf_if.sv
// Bus bundle for eth_tx_fbuf.
// master: frame producer/consumer side (drives a_wr/a_din/a_commit/a_flush, b_rd)
// slave : the frame buffer itself (drives status and the FWFT read port)
interface eth_tx_fbuf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              a_wr;
  logic [DATA_W-1:0] a_din;
  logic              a_commit;
  logic              a_flush;
  logic              a_full;
  logic [ADDR_W:0]   a_used;
  logic              a_ovf;
  logic              b_avail;
  logic              b_valid;
  logic [DATA_W-1:0] b_dout;
  logic              b_sof;
  logic              b_eof;
  logic              b_rd;

  modport master (
    output a_wr, a_din, a_commit, a_flush, b_rd,
    input  a_full, a_used, a_ovf, b_avail, b_valid, b_dout, b_sof, b_eof
  );

  modport slave (
    input  a_wr, a_din, a_commit, a_flush, b_rd,
    output a_full, a_used, a_ovf, b_avail, b_valid, b_dout, b_sof, b_eof
  );
endinterface

// File: rtl/eth_tx_fbuf.sv
// eth_tx_fbuf - dual-clock Ethernet TX frame buffer.
// Bus side (a_clk) writes payload bytes into an open frame and commits whole
// frames into a queue of up to 2**FRAME_W slots over a shared 2**ADDR_W RAM.
// Line side (b_clk) pops committed frames byte by byte, FWFT, with sof/eof.
// Ports: a_clk, b_clk clocks; rst async active-low (both domains);
//        bus (eth_tx_fbuf_if.slave): a_wr/a_din/a_commit/a_flush in,
//        a_full/a_used/a_ovf out; b_rd in, b_avail/b_valid/b_dout/b_sof/b_eof out.
// Optional: define ETH_TX_FBUF_PREAMBLE_EN to prefix each frame with PRE_LEN
//           bytes of 0x55 and an 0xD5 SFD.
module eth_tx_fbuf #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int FRAME_W = 2,
  parameter int PRE_LEN = 7
) (
  input  logic         a_clk,
  input  logic         rst,
  input  logic         b_clk,
  eth_tx_fbuf_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FRAMES = 1 << FRAME_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
`ifdef ETH_TX_FBUF_PREAMBLE_EN
  localparam logic [1:0] PRE  = 2'd2;
  localparam int PC_W = $clog2(PRE_LEN + 2);
`endif

  typedef logic [FRAME_W:0] fcnt_t;

  function automatic fcnt_t g2b(fcnt_t g);
    fcnt_t b;
    b[FRAME_W] = g[FRAME_W];
    for (int i = FRAME_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Storage: written only in a_clk, read in b_clk once the synced count covers it.
  logic [DATA_W-1:0] mem        [DEPTH];
  logic [ADDR_W-1:0] slot_start [FRAMES];
  logic [ADDR_W:0]   slot_len   [FRAMES];

  // ---------------- write side (a_clk) ----------------
  logic [ADDR_W-1:0] wp, open_start;
  logic [ADDR_W:0]   open_len, used, rel_len, inc, dsc;
  logic              bad, ovf, full, rel;
  logic              do_wr, do_commit, do_discard, drop;
  fcnt_t             wf_bin, wf_gray, wf_nxt, rel_cnt, rf_s1, rf_s2;

  // rel_cnt trails the synced read count; each step retires one slot's bytes.
  assign rel        = g2b(rf_s2) != rel_cnt;
  assign rel_len    = rel ? slot_len[rel_cnt[FRAME_W-1:0]] : '0;
  assign full       = (used == (ADDR_W+1)'(DEPTH)) |
                      ((wf_bin - rel_cnt) == (FRAME_W+1)'(FRAMES));
  assign do_discard = bus.a_flush | (bus.a_commit & ((open_len == '0) | bad));
  assign do_commit  = bus.a_commit & ~bus.a_flush & (open_len != '0) & ~bad;
  assign do_wr      = bus.a_wr & ~bus.a_flush & ~bus.a_commit & ~full;
  assign drop       = bus.a_wr & ~bus.a_flush & ~bus.a_commit & full;
  assign inc        = {{ADDR_W{1'b0}}, do_wr};
  assign dsc        = do_discard ? open_len : '0;
  assign wf_nxt     = wf_bin + fcnt_t'(1);

  always_ff @(posedge a_clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; open_start <= '0; open_len <= '0; used <= '0;
      bad <= 1'b0; ovf <= 1'b0;
      wf_bin <= '0; wf_gray <= '0; rel_cnt <= '0;
    end else begin
      used <= used + inc - dsc - rel_len;
      if (rel) rel_cnt <= rel_cnt + fcnt_t'(1);
      if (do_discard) begin
        wp <= open_start; open_len <= '0; bad <= 1'b0; ovf <= 1'b0;
      end else if (do_commit) begin
        wf_bin <= wf_nxt; wf_gray <= wf_nxt ^ (wf_nxt >> 1);
        open_start <= wp; open_len <= '0; ovf <= 1'b0;
      end else if (do_wr) begin
        wp <= wp + ADDR_W'(1); open_len <= open_len + (ADDR_W+1)'(1);
      end else if (drop) begin
        ovf <= 1'b1; bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (do_wr) mem[wp] <= bus.a_din;
    if (do_commit) begin
      slot_start[wf_bin[FRAME_W-1:0]] <= open_start;
      slot_len[wf_bin[FRAME_W-1:0]]   <= open_len;
    end
  end

  assign bus.a_full = full;
  assign bus.a_used = used;
  assign bus.a_ovf  = ovf;

  // ---------------- read side (b_clk) ----------------
  logic [1:0]        state;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   rem;
  logic              first, avail;
  fcnt_t             rf_bin, rf_gray, rf_nxt, wf_s1, wf_s2;
`ifdef ETH_TX_FBUF_PREAMBLE_EN
  logic [PC_W-1:0]   pre_cnt;
`endif

  always_ff @(posedge a_clk or negedge rst) begin
    if (!rst) begin
      rf_s1 <= '0; rf_s2 <= '0;
    end else begin
      rf_s1 <= rf_gray; rf_s2 <= rf_s1;
    end
  end

  assign avail  = g2b(wf_s2) != rf_bin;
  assign rf_nxt = rf_bin + fcnt_t'(1);

  always_ff @(posedge b_clk or negedge rst) begin
    if (!rst) begin
      wf_s1 <= '0; wf_s2 <= '0; rf_bin <= '0; rf_gray <= '0;
      state <= IDLE; rp <= '0; rem <= '0; first <= 1'b0;
`ifdef ETH_TX_FBUF_PREAMBLE_EN
      pre_cnt <= '0;
`endif
    end else begin
      wf_s1 <= wf_gray; wf_s2 <= wf_s1;
      case (state)
        IDLE: if (avail) begin
          rp  <= slot_start[rf_bin[FRAME_W-1:0]];
          rem <= slot_len[rf_bin[FRAME_W-1:0]];
`ifdef ETH_TX_FBUF_PREAMBLE_EN
          state <= PRE; pre_cnt <= '0; first <= 1'b0;
`else
          state <= DATA; first <= 1'b1;
`endif
        end
`ifdef ETH_TX_FBUF_PREAMBLE_EN
        PRE: if (bus.b_rd) begin
          if (pre_cnt == PC_W'(PRE_LEN)) state <= DATA;
          else pre_cnt <= pre_cnt + PC_W'(1);
        end
`endif
        DATA: if (bus.b_rd) begin
          rp <= rp + ADDR_W'(1); rem <= rem - (ADDR_W+1)'(1); first <= 1'b0;
          // Last byte consumed: release the slot back to the write side.
          if (rem == (ADDR_W+1)'(1)) begin
            rf_bin <= rf_nxt; rf_gray <= rf_nxt ^ (rf_nxt >> 1); state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.b_valid = state != IDLE;
    bus.b_dout  = mem[rp];
    bus.b_sof   = (state == DATA) & first;
    bus.b_eof   = (state == DATA) & (rem == (ADDR_W+1)'(1));
`ifdef ETH_TX_FBUF_PREAMBLE_EN
    if (state == PRE) begin
      bus.b_dout = (pre_cnt == PC_W'(PRE_LEN)) ? DATA_W'(8'hD5) : DATA_W'(8'h55);
      bus.b_sof  = pre_cnt == '0;
    end
`endif
  end

  assign bus.b_avail = avail;
endmodule

// File: tb/tb_eth_tx_fbuf.sv
module tb_eth_tx_fbuf;
  logic a_clk = 1'b0, b_clk = 1'b0, rst = 1'b0;
  always #5 a_clk = ~a_clk;
  initial begin #2; forever #15 b_clk = ~b_clk; end

  eth_tx_fbuf_if #(.DATA_W(8), .ADDR_W(8)) bus();
  eth_tx_fbuf #(.DATA_W(8), .ADDR_W(8), .FRAME_W(2), .PRE_LEN(7)) dut (
    .a_clk(a_clk), .rst(rst), .b_clk(b_clk), .bus(bus)
  );

  int n_chk = 0, n_fail = 0;
  int exp_wp = 0;
  logic [9:0] sb[$];  // {byte, sof, eof}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d);
    @(negedge a_clk); bus.a_wr = 1'b1; bus.a_din = d;
    @(posedge a_clk); #1; bus.a_wr = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge a_clk); bus.a_commit = 1'b1;
    @(posedge a_clk); #1; bus.a_commit = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge a_clk); bus.a_flush = 1'b1;
    @(posedge a_clk); #1; bus.a_flush = 1'b0;
  endtask

  // Writes n bytes base, base+step, ... and commits; pushes the expected line stream.
  task automatic send_frame(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] d;
    d = base;
`ifdef ETH_TX_FBUF_PREAMBLE_EN
    for (int i = 0; i < 7; i++) sb.push_back({8'h55, (i == 0), 1'b0});
    sb.push_back({8'hD5, 1'b0, 1'b0});
`endif
    for (int i = 0; i < n; i++) begin
      wr_byte(d);
`ifdef ETH_TX_FBUF_PREAMBLE_EN
      sb.push_back({d, 1'b0, (i == n - 1)});
`else
      sb.push_back({d, (i == 0), (i == n - 1)});
`endif
      d = d + step;
    end
    exp_wp = (exp_wp + n) % 256;
    do_commit();
  endtask

  // Pops n bytes with b_rd held high, comparing against the scoreboard.
  task automatic pop_n(input int n);
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge b_clk);
      while (!bus.b_valid && t < 60) begin @(negedge b_clk); t++; end
      if (!bus.b_valid) begin
        chk("pop_timeout", 32'(bus.b_valid), 32'd1);
        break;
      end
      e = sb.pop_front();
      chk("b_dout", 32'(bus.b_dout), 32'(e[9:2]));
      chk("b_sof", 32'(bus.b_sof), 32'(e[1]));
      chk("b_eof", 32'(bus.b_eof), 32'(e[0]));
      bus.b_rd = 1'b1;
      @(posedge b_clk); #1;
    end
    bus.b_rd = 1'b0;
  endtask

  task automatic pop_all();
    pop_n(sb.size());
  endtask

  task automatic wait_used(input string tag, input int v);
    int t = 0;
    while (bus.a_used !== 9'(v) && t < 50) begin @(negedge a_clk); t++; end
    chk(tag, 32'(bus.a_used), 32'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, n;
    bus.a_wr = 1'b0; bus.a_din = '0; bus.a_commit = 1'b0; bus.a_flush = 1'b0; bus.b_rd = 1'b0;

    // Reset state
    repeat (3) @(negedge a_clk);
    chk("rst_a_full", 32'(bus.a_full), 32'd0);
    chk("rst_a_used", 32'(bus.a_used), 32'd0);
    chk("rst_a_ovf", 32'(bus.a_ovf), 32'd0);
    chk("rst_b_avail", 32'(bus.b_avail), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_b_sof", 32'(bus.b_sof), 32'd0);
    chk("rst_b_eof", 32'(bus.b_eof), 32'd0);
    rst = 1'b1;
    @(negedge a_clk);

    // Basic 3-byte frame, commit-to-avail latency
    send_frame(3, 8'h11, 8'h11);
    chk("t1_a_used", 32'(bus.a_used), 32'd3);
    k = 0;
    while (!bus.b_avail && k < 3) begin @(posedge b_clk); #1; k++; end
    chk("t1_b_avail_latency", 32'(bus.b_avail), 32'd1);
    pop_all();
    wait_used("t1_used_release", 0);

    // Four queued frames fill every slot
    for (int f = 0; f < 4; f++) send_frame(2, 8'(8'hA0 + 2 * f), 8'h01);
    @(negedge a_clk);
    chk("t2_a_full", 32'(bus.a_full), 32'd1);
    chk("t2_a_used", 32'(bus.a_used), 32'd8);
    wr_byte(8'hEE);
    @(negedge a_clk);
    chk("t2_a_ovf", 32'(bus.a_ovf), 32'd1);
    chk("t2_used_after_drop", 32'(bus.a_used), 32'd8);
    pop_n(2);
    k = 0;
    while (bus.a_full && k < 50) begin @(negedge a_clk); k++; end
    chk("t2_a_full_cleared", 32'(bus.a_full), 32'd0);
    do_flush();
    chk("t2_ovf_flush", 32'(bus.a_ovf), 32'd0);
    pop_all();
    wait_used("t2_used_release", 0);

    // Fill the whole RAM without committing, then flush
    for (int i = 0; i < 256; i++) wr_byte(8'(i));
    @(negedge a_clk);
    chk("t3_a_used_full", 32'(bus.a_used), 32'd256);
    chk("t3_a_full", 32'(bus.a_full), 32'd1);
    do_flush();
    @(negedge a_clk);
    chk("t3_used_flush", 32'(bus.a_used), 32'd0);
    chk("t3_ovf_flush", 32'(bus.a_ovf), 32'd0);
    repeat (6) @(negedge b_clk);
    chk("t3_b_avail", 32'(bus.b_avail), 32'd0);

    // Empty commit and overflowed-frame commit consume no slot
    do_commit();
    repeat (6) @(negedge b_clk);
    chk("t4_empty_commit_avail", 32'(bus.b_avail), 32'd0);
    for (int i = 0; i < 257; i++) wr_byte(8'(i));
    @(negedge a_clk);
    chk("t4_ovf_set", 32'(bus.a_ovf), 32'd1);
    do_commit();
    @(negedge a_clk);
    chk("t4_used_discard", 32'(bus.a_used), 32'd0);
    chk("t4_ovf_commit", 32'(bus.a_ovf), 32'd0);
    repeat (6) @(negedge b_clk);
    chk("t4_bad_commit_avail", 32'(bus.b_avail), 32'd0);

    // Payload spanning the address wrap 0xFE..0x01
    n = (254 - exp_wp + 256) % 256;
    if (n > 0) begin
      send_frame(n, 8'h00, 8'h01);
      pop_all();
      wait_used("t5_filler_release", 0);
    end
    send_frame(4, 8'hC1, 8'h01);
    chk("t5_a_used", 32'(bus.a_used), 32'd4);
    pop_all();
    wait_used("t5_used_release", 0);

`ifdef ETH_TX_FBUF_PREAMBLE_EN
    send_frame(1, 8'hAB, 8'h00);
    pop_all();
    wait_used("t6_used_release", 0);
    send_frame(1, 8'hAC, 8'h00);
    pop_n(2);
`else
    send_frame(3, 8'h71, 8'h01);
    pop_n(1);
`endif
    // Asynchronous reset in the middle of a frame
    #3; rst = 1'b0; #1;
    chk("t6_rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("t6_rst_b_avail", 32'(bus.b_avail), 32'd0);
    chk("t6_rst_a_used", 32'(bus.a_used), 32'd0);
    sb.delete();
    exp_wp = 0;
    @(negedge a_clk); rst = 1'b1;
    @(negedge a_clk);
    send_frame(2, 8'h5A, 8'h01);
    pop_all();
    wait_used("t6_post_rst_release", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_tx_fbuf.md
Name: eth_tx_fbuf

Overview:
Parametrised dual-clock transmit frame buffer. It is the successor of the single-frame Ethernet TX memory. The bus side (a_clk) writes payload bytes and commits whole frames into a queue of up to 2**FRAME_W frames in a shared 2**ADDR_W-entry RAM. The line side (b_clk) pops committed frames byte by byte in first-word-fall-through (FWFT) style with frame delimiters, optionally prefixed by preamble and SFD. It sits between the AHB peripheral register file and the Manchester frame serialiser.

Parameters:
DATA_W, 8, data byte width
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W entries
FRAME_W, 2, frame-slot index width; FRAMES = 2**FRAME_W queued frames max
PRE_LEN, 7, preamble bytes (0x55) before SFD (0xD5); used only with the optional feature

Ports:
a_clk  in  1  write-side clock
rst  in  1  asynchronous active-low reset, both domains
b_clk  in  1  read-side clock
a_wr  in  1  write one payload byte into the open frame
a_din  in  DATA_W  payload byte
a_commit  in  1  close the open frame and queue it
a_flush  in  1  discard the open (uncommitted) frame
a_full  out  1  no free byte or no free frame slot
a_used  out  ADDR_W+1  bytes occupied (committed plus open)
a_ovf  out  1  sticky: a write was dropped; cleared by a_flush or a_commit
b_avail  out  1  at least one committed frame is visible in b_clk
b_valid  out  1  b_dout holds a valid byte
b_dout  out  DATA_W  current byte (FWFT)
b_sof  out  1  current byte is the first byte of the frame
b_eof  out  1  current byte is the last byte of the frame
b_rd  in  1  consume the current byte; ignored when b_valid=0

Behaviour:
- Reset (rst=0, asynchronous): all pointers, counters and slot indices cleared.
  - Outputs: a_full=0, a_used=0, a_ovf=0, b_avail=0, b_valid=0, b_sof=0, b_eof=0, b_dout=mem[0].
  - Reset mid-frame drops all queued and open data. RAM contents are not cleared.
- Write side, per a_clk:
  - a_wr with a_full=0: mem[wp] <= a_din; wp and open length increment; a_used increments. wp wraps modulo DEPTH.
  - a_wr with a_full=1: byte dropped; a_ovf <= 1; open frame marked bad.
  - a_commit: if open length > 0 and frame not bad, store {start address, length} in slot wf; wf increments modulo FRAMES; the frame's bytes stay counted in a_used. Otherwise the frame is discarded, as for a_flush.
  - a_flush: wp returns to the open-frame start; a_used decreases by the open length; a_ovf cleared.
  - Priority within a cycle: a_flush > a_commit > a_wr. A byte written in the same cycle as a_commit is not part of that frame.
  - a_full = (a_used == DEPTH) | (committed-unreleased frames == FRAMES).
- Clock-domain crossing:
  - Committed-frame count wf (FRAME_W+1 bits, Gray) is synchronised to b_clk through 2 flops.
  - Released-frame count rf (FRAME_W+1 bits, Gray) is synchronised to a_clk through 2 flops.
  - Slot records and RAM bytes are read in b_clk only after the synchronised count shows them committed.
  - On each a_clk cycle where the synchronised rf advances, a_used decreases by that slot's length, one slot per cycle. A simultaneous write or flush is combined arithmetically.
  - Commit-to-b_avail latency is 3 b_clk edges maximum after the commit edge.
- Read FSM (b_clk), states IDLE, [PRE], DATA:
  - IDLE: b_valid=0. When b_avail=1, load the slot rf record (rp <= start, remaining <= length) and go to DATA (PRE if enabled) on the next edge.
  - DATA:
    - Outputs: b_valid=1, b_dout=mem[rp] (asynchronous RAM read), b_sof=1 on the first payload byte (when PRE is not used), b_eof = (remaining==1).
    - b_rd: rp++ (wraps modulo DEPTH), remaining--.
    - b_rd on the eof byte: rf increments and the FSM returns to IDLE. A back-to-back frame restarts after one idle cycle.
  - b_rd while b_valid=0: no effect.

Optional Feature:
ETH_TX_FBUF_PREAMBLE_EN:
- Defined: PRE state emits PRE_LEN bytes of 0x55, then 0xD5, with b_valid=1; each b_rd advances. b_sof=1 on the first 0x55, not on the payload byte. The SFD b_rd enters DATA. Frame length seen on b_dout = payload + PRE_LEN + 1.
- Undefined: PRE state and its counter are absent; IDLE goes directly to DATA; b_sof marks the first payload byte.

Test Plan:
- Reset, write 0x11,0x22,0x33 and commit; b_clk = a_clk/3 -> b_avail within 3 b_clk; bytes 0x11(sof),0x22,0x33(eof) popped with b_rd held high; then a_used returns to 0.
- Queue 4 frames of 2 bytes, FRAME_W=2 -> a_full=1 after the 4th commit; a 5th a_wr is dropped and a_ovf=1; after one frame is popped, a_full=0.
- Fill DEPTH=256 bytes without committing -> a_used=256, a_full=1; a_flush -> a_used=0, a_ovf=0, b_avail stays 0.
- Commit with open length 0, and commit of an overflowed frame -> no slot consumed; b_avail stays 0.
- Frames positioned so payload spans address 0xFE..0x01 -> bytes read in order across the wrap; a_used is correct after release.
- With ETH_TX_FBUF_PREAMBLE_EN, 1-byte frame 0xAB -> b_dout sequence 0x55 x7 (sof on first), 0xD5, 0xAB(eof); rst pulsed mid-preamble -> b_valid=0 immediately and b_avail=0.
